// File: rtl/result_display_scanner.sv
// Result capture and hex display scanner.
// Samples the processor result bus once per slow-clock period, just after the
// slow clock's falling edge has been seen through a three-flop synchronizer,
// and multiplexes the captured value onto a four-digit active-low seven-segment
// display.
module result_display_scanner #(
   parameter int DIGIT_DIV = 4,
   parameter int CNT_W     = 8
) (
   input  logic              clock_in,
   input  logic              reset,
   input  logic              clock_slow,
   input  logic [15:0]       finaloutput,
   input  logic              freeze,
   output logic [15:0]       captured,
   output logic              new_result,
   output logic [CNT_W-1:0]  updates,
   output logic [3:0]        an,
   output logic [6:0]        seg,
   output logic              dp
);

   // A one-cycle dwell still needs a one-bit divider register.
   localparam int DIV_W = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIGIT_DIV - 1);

   // Active-low gfedcba pattern for one hex digit.
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'b1000000;
         4'h1:    pat = 7'b1111001;
         4'h2:    pat = 7'b0100100;
         4'h3:    pat = 7'b0110000;
         4'h4:    pat = 7'b0011001;
         4'h5:    pat = 7'b0010010;
         4'h6:    pat = 7'b0000010;
         4'h7:    pat = 7'b1111000;
         4'h8:    pat = 7'b0000000;
         4'h9:    pat = 7'b0010000;
         4'hA:    pat = 7'b0001000;
         4'hB:    pat = 7'b0000011;
         4'hC:    pat = 7'b1000110;
         4'hD:    pat = 7'b0100001;
         4'hE:    pat = 7'b0000110;
         4'hF:    pat = 7'b0001110;
         default: pat = 7'b1111111;
      endcase
      return pat;
   endfunction

   // sync_q[0]=q1, sync_q[1]=q2, sync_q[2]=q3
   logic [2:0]       sync_q, sync_d;
   logic [15:0]      captured_q, captured_d;
   logic             new_q, new_d;
   logic [CNT_W-1:0] updates_q, updates_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       digit_q, digit_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;

   logic             fall_s;
   logic             capture_s;
   logic             div_last_s;
   logic [3:0]       nibble_s;

   // Falling-edge detect and capture decision; a frozen fall is simply dropped.
   always_comb begin
      sync_d    = {sync_q[1:0], clock_slow};
      fall_s    = sync_q[2] & ~sync_q[1];
      capture_s = fall_s & ~freeze;
      if (capture_s) begin
         captured_d = finaloutput;
         updates_d  = updates_q + CNT_W'(1);
         new_d      = (finaloutput != captured_q);
      end else begin
         captured_d = captured_q;
         updates_d  = updates_q;
         new_d      = 1'b0;
      end
   end

   // Digit dwell divider and digit index advance.
   always_comb begin
      div_last_s = (div_q == DIV_LAST);
      if (div_last_s) begin
         div_d   = '0;
         digit_d = digit_q + 2'd1;
      end else begin
         div_d   = div_q + DIV_W'(1);
         digit_d = digit_q;
      end
   end

   // Select the lit digit's enable and nibble from the current index and data.
   always_comb begin
      case (digit_q)
         2'd0: begin
            an_d     = 4'b1110;
            nibble_s = captured_q[3:0];
         end
         2'd1: begin
            an_d     = 4'b1101;
            nibble_s = captured_q[7:4];
         end
         2'd2: begin
            an_d     = 4'b1011;
            nibble_s = captured_q[11:8];
         end
         2'd3: begin
            an_d     = 4'b0111;
            nibble_s = captured_q[15:12];
         end
         default: begin
            an_d     = 4'b1110;
            nibble_s = captured_q[3:0];
         end
      endcase
      seg_d = hex7(nibble_s);
   end

   // State registers; reset wins over a capture in the same cycle.
   always_ff @(posedge clock_in) begin
      if (!reset) begin
         sync_q     <= 3'b000;
         captured_q <= 16'h0000;
         new_q      <= 1'b0;
         updates_q  <= '0;
         div_q      <= '0;
         digit_q    <= 2'd0;
         an_q       <= 4'b1110;
         seg_q      <= 7'b1000000;
      end else begin
         sync_q     <= sync_d;
         captured_q <= captured_d;
         new_q      <= new_d;
         updates_q  <= updates_d;
         div_q      <= div_d;
         digit_q    <= digit_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign captured   = captured_q;
   assign new_result = new_q;
   assign updates    = updates_q;
   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = 1'b1;

endmodule

// File: tb/tb_result_display_scanner.sv
// Randomized bench for result_display_scanner with a cycle-level reference
// model: a capture happens three fast edges after clock_slow is first sampled
// low (having been high), unless freeze is set; the digit shown after edge k
// since reset is (k/DIGIT_DIV) mod 4, reflecting data one cycle late.
module tb_result_display_scanner;

   localparam int DIGIT_DIV = 4;
   localparam int CNT_W     = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic             clock_slow;
   logic [15:0]      finaloutput;
   logic             freeze;
   logic [15:0]      captured;
   logic             new_result;
   logic [CNT_W-1:0] updates;
   logic [3:0]       an;
   logic [6:0]       seg;
   logic             dp;

   result_display_scanner #(.DIGIT_DIV(DIGIT_DIV), .CNT_W(CNT_W)) dut (
      .clock_in(clk), .reset(reset), .clock_slow(clock_slow),
      .finaloutput(finaloutput), .freeze(freeze), .captured(captured),
      .new_result(new_result), .updates(updates), .an(an), .seg(seg), .dp(dp)
   );

   int total = 0;
   int bad   = 0;

   logic [6:0] hex_tab [16];

   // reference model state
   logic [15:0]      m_cap;
   logic             m_new;
   logic [CNT_W-1:0] m_upd;
   logic [3:0]       m_an;
   logic [6:0]       m_seg;
   logic             s1, s2, s3;   // clock_slow sampled 1, 2, 3 edges ago
   int               k;
   int               n_caps;

   // slow clock generator state
   logic        slow_run;
   int          half;
   int          slow_cnt;
   logic [15:0] fin_pending;

   task automatic tick();
      int  d;
      logic cap;
      @(posedge clk);
      if (!reset) begin
         m_cap = 16'h0; m_new = 1'b0; m_upd = '0;
         m_an = 4'b1110; m_seg = hex_tab[0];
         s1 = 1'b0; s2 = 1'b0; s3 = 1'b0; k = 0;
      end else begin
         d     = (k / DIGIT_DIV) % 4;
         m_an  = ~(4'b0001 << d);
         m_seg = hex_tab[(m_cap >> (4 * d)) & 16'h000F];
         k++;
         cap   = s3 && !s2 && !freeze;
         m_new = cap && (finaloutput != m_cap);
         if (cap) begin
            m_cap = finaloutput;
            m_upd = m_upd + 1'b1;
            n_caps++;
         end
         s3 = s2; s2 = s1; s1 = clock_slow;
      end
      #1;
      if (slow_run) begin
         slow_cnt++;
         if (slow_cnt >= half) begin
            slow_cnt   = 0;
            clock_slow = ~clock_slow;
            if (clock_slow) finaloutput = fin_pending;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; freeze = 1'b0; clock_slow = 1'b0; finaloutput = 16'h0;
      slow_run = 1'b0; slow_cnt = 0; half = 3; fin_pending = 16'h0;
      tick(); tick();
      if ({captured, new_result, updates} !== {16'h0, 1'b0, 8'h00}) begin
         bad++; $display("FAIL reset_regs got=%h want=%h", {captured, new_result, updates}, 25'h0);
      end
      total++;
      if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
         bad++; $display("FAIL reset_disp got=%b want=%b", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
      end
      total++;
      reset = 1'b1;
   endtask

   task automatic test_idle_scan();
      logic [3:0] an_seq [4];
      an_seq[0] = 4'b1110; an_seq[1] = 4'b1101; an_seq[2] = 4'b1011; an_seq[3] = 4'b0111;
      for (int i = 1; i <= 20; i++) begin
         tick();
         // after edge i past reset the shown digit is ((i-1)/4) mod 4
         if ({an, seg, captured, updates, dp} !== {an_seq[((i - 1) / 4) % 4], 7'b1000000, 16'h0, 8'h00, 1'b1}) begin
            bad++; $display("FAIL idle_scan i=%0d got=%h want=%h", i, {an, seg, captured, updates, dp},
                            {an_seq[((i - 1) / 4) % 4], 7'b1000000, 16'h0, 8'h00, 1'b1});
         end
         total++;
      end
   endtask

   task automatic test_capture_1a2f();
      int pulses;
      int waited;
      pulses = 0; waited = 0;
      fin_pending = 16'h1A2F; half = 3; slow_cnt = 0; slow_run = 1'b1;
      while (pulses == 0 && waited < 40) begin
         tick(); waited++;
         if (new_result) pulses++;
         if ({captured, new_result, updates, an, seg, dp} !== {m_cap, m_new, m_upd, m_an, m_seg, 1'b1}) begin
            bad++; $display("FAIL cap_model t=%0t got=%h want=%h", $time,
                            {captured, new_result, updates, an, seg, dp}, {m_cap, m_new, m_upd, m_an, m_seg, 1'b1});
         end
         total++;
      end
      if ({pulses, captured, updates} !== {32'd1, 16'h1A2F, 8'd1}) begin
         bad++; $display("FAIL cap_first pulses=%0d captured=%h updates=%0d want 1/1a2f/1", pulses, captured, updates);
      end
      total++;
      tick(); tick();
      for (int i = 0; i < 16; i++) begin
         logic [6:0] want;
         tick();
         case (an)
            4'b1110: want = 7'b0001110;
            4'b1101: want = 7'b0100100;
            4'b1011: want = 7'b0001000;
            4'b0111: want = 7'b1111001;
            default: want = 7'bxxxxxxx;
         endcase
         if (seg !== want || new_result !== 1'b0) begin
            bad++; $display("FAIL seg_1a2f an=%b seg=%b want=%b new=%b", an, seg, want, new_result);
         end
         total++;
      end
   endtask

   task automatic test_same_value();
      logic [CNT_W-1:0] start;
      start = m_upd;
      for (int i = 0; i < 5 * 2 * half; i++) begin
         tick();
         if (new_result !== 1'b0 || {captured, updates, an, seg} !== {m_cap, m_upd, m_an, m_seg}) begin
            bad++; $display("FAIL same_val t=%0t new=%b got=%h want=%h", $time, new_result,
                            {captured, updates, an, seg}, {m_cap, m_upd, m_an, m_seg});
         end
         total++;
      end
      if (updates !== start + 8'd5) begin
         bad++; $display("FAIL same_count got=%0d want=%0d", updates, start + 8'd5);
      end
      total++;
   endtask

   task automatic test_freeze();
      logic [CNT_W-1:0] start;
      int waited;
      start = m_upd; waited = 0;
      freeze = 1'b1; fin_pending = 16'hBEEF;
      for (int i = 0; i < 4 * half; i++) begin
         tick();
         if ({captured, new_result, updates} !== {16'h1A2F, 1'b0, start}) begin
            bad++; $display("FAIL frozen got=%h want=%h", {captured, new_result, updates}, {16'h1A2F, 1'b0, start});
         end
         total++;
      end
      freeze = 1'b0;
      while (!new_result && waited < 4 * half + 4) begin
         tick(); waited++;
         if ({captured, new_result, updates, an, seg} !== {m_cap, m_new, m_upd, m_an, m_seg}) begin
            bad++; $display("FAIL thaw_model got=%h want=%h", {captured, new_result, updates, an, seg},
                            {m_cap, m_new, m_upd, m_an, m_seg});
         end
         total++;
      end
      if ({new_result, captured, updates} !== {1'b1, 16'hBEEF, start + 8'd1}) begin
         bad++; $display("FAIL thaw_cap got=%h want=%h", {new_result, captured, updates}, {1'b1, 16'hBEEF, start + 8'd1});
      end
      total++;
   endtask

   task automatic test_wrap();
      logic [CNT_W-1:0] start;
      int target;
      start = m_upd; target = n_caps + 256;
      for (int i = 0; i < 2000 && n_caps < target; i++) begin
         fin_pending = 16'($urandom);
         tick();
         if ({captured, new_result, updates, an, seg} !== {m_cap, m_new, m_upd, m_an, m_seg}) begin
            bad++; $display("FAIL wrap_model t=%0t got=%h want=%h", $time,
                            {captured, new_result, updates, an, seg}, {m_cap, m_new, m_upd, m_an, m_seg});
         end
         total++;
      end
      if (n_caps != target || updates !== start) begin
         bad++; $display("FAIL wrap_count caps=%0d/%0d updates=%0d want=%0d", n_caps, target, updates, start);
      end
      total++;
   endtask

   task automatic test_reset_on_fall();
      int waited;
      logic hit;
      fin_pending = 16'h00FF; waited = 0; hit = 1'b0;
      while (!hit && waited < 60) begin
         tick(); waited++;
         hit = (finaloutput == 16'h00FF) && s2 && !s1;
      end
      if (!hit) begin
         bad++; $display("FAIL rst_fall_wait no fall cycle seen got=0 want=1");
      end
      total++;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      if ({captured, new_result, updates, an} !== {16'h0, 1'b0, 8'h00, 4'b1110}) begin
         bad++; $display("FAIL rst_fall got=%h want=%h", {captured, new_result, updates, an}, {16'h0, 1'b0, 8'h00, 4'b1110});
      end
      total++;
      waited = 0;
      while (!new_result && waited < 4 * half + 4) begin
         tick(); waited++;
         if ({captured, updates} !== {m_cap, m_upd}) begin
            bad++; $display("FAIL rst_fall_model got=%h want=%h", {captured, updates}, {m_cap, m_upd});
         end
         total++;
      end
      if ({new_result, captured, updates} !== {1'b1, 16'h00FF, 8'd1}) begin
         bad++; $display("FAIL rst_fall_cap got=%h want=%h", {new_result, captured, updates}, {1'b1, 16'h00FF, 8'd1});
      end
      total++;
   endtask

   task automatic test_random();
      for (int seg_i = 0; seg_i < 4; seg_i++) begin
         half = $urandom_range(3, 5);
         for (int i = 0; i < 300; i++) begin
            reset       = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            freeze      = ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0;
            fin_pending = ($urandom_range(0, 3) == 0) ? finaloutput : 16'($urandom);
            tick();
            if ({captured, new_result, updates, an, seg, dp} !== {m_cap, m_new, m_upd, m_an, m_seg, 1'b1}) begin
               bad++; $display("FAIL random t=%0t got=%h want=%h", $time,
                               {captured, new_result, updates, an, seg, dp}, {m_cap, m_new, m_upd, m_an, m_seg, 1'b1});
            end
            total++;
         end
      end
      reset = 1'b1; freeze = 1'b0;
   endtask

   initial begin
      hex_tab[0]  = 7'b1000000; hex_tab[1]  = 7'b1111001; hex_tab[2]  = 7'b0100100; hex_tab[3]  = 7'b0110000;
      hex_tab[4]  = 7'b0011001; hex_tab[5]  = 7'b0010010; hex_tab[6]  = 7'b0000010; hex_tab[7]  = 7'b1111000;
      hex_tab[8]  = 7'b0000000; hex_tab[9]  = 7'b0010000; hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
      hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001; hex_tab[14] = 7'b0000110; hex_tab[15] = 7'b0001110;
      n_caps = 0;
      test_reset();
      test_idle_scan();
      test_capture_1a2f();
      test_same_value();
      test_freeze();
      test_wrap();
      test_reset_on_fall();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
